// File: rtl/cbus_writeback_pkg.sv
// Shared datapath constants and the 4-bit select code space used by A_SEL, C_SEL and INC_SEL.
package cbus_writeback_pkg;

  localparam int unsigned WIDTH     = 19;
  localparam int unsigned NREG      = 12;
  localparam int unsigned NSLOT     = NREG + 2;
  localparam int unsigned SLOT_DMAR = 0;
  localparam int unsigned SLOT_DMDR = 1;

  typedef enum logic [3:0] {
    csel_none = 4'd0,
    csel_dmar = 4'd1,
    csel_dmdr = 4'd2,
    csel_r0   = 4'd3,
    csel_r1   = 4'd4,
    csel_r2   = 4'd5,
    csel_r3   = 4'd6,
    csel_r4   = 4'd7,
    csel_r5   = 4'd8,
    csel_r6   = 4'd9,
    csel_r7   = 4'd10,
    csel_r8   = 4'd11,
    csel_r9   = 4'd12,
    csel_r10  = 4'd13,
    csel_r11  = 4'd14,
    csel_rsvd = 4'd15
  } csel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } pend_state_e;

  // Codes 1..14 map to slots 0..13 (DMAR, DMDR, R0..R11); none/reserved decode to no slot.
  function automatic logic [NSLOT-1:0] sel_onehot(input logic [3:0] sel);
    logic [NSLOT-1:0] hot;
    hot = '0;
    if (sel >= 4'd1 && sel <= 4'd14) hot = NSLOT'(1) << (sel - 4'd1);
    return hot;
  endfunction

endpackage

// File: rtl/cbus_reg.sv
// One architectural register: load has priority over increment, increment wraps modulo 2^WIDTH.
module cbus_reg
  import cbus_writeback_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (ld)  q <= ld_data;
    else if (inc) q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/cbus_writeback.sv
// C bus write-back, register increment and DMDR memory-load path with a one-entry hold buffer.
// Optional zero flag on C bus writes is enabled by defining CBUS_WB_ZFLAG_EN.
module cbus_writeback
  import cbus_writeback_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       C_SEL,
  input  logic [WIDTH-1:0] c_in,
  input  logic [3:0]       INC_SEL,
  input  logic             mem_rd_valid,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             mem_rd_ready,
`ifdef CBUS_WB_ZFLAG_EN
  output logic             zflag,
`endif
  output logic [WIDTH-1:0] DMAR,
  output logic [WIDTH-1:0] DMDR,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic [WIDTH-1:0] R6,
  output logic [WIDTH-1:0] R7,
  output logic [WIDTH-1:0] R8,
  output logic [WIDTH-1:0] R9,
  output logic [WIDTH-1:0] R10,
  output logic [WIDTH-1:0] R11
);

  pend_state_e      state, state_n;
  logic [WIDTH-1:0] pend_data;
  logic             pend_cap;
  logic [NSLOT-1:0] c_hot, inc_hot, ld_vec;
  logic             cpu_dmdr, mem_fire, dmdr_ld;
  logic [WIDTH-1:0] dmdr_data;
  logic [WIDTH-1:0] ld_data [NSLOT];
  logic [WIDTH-1:0] regs [NSLOT];

  assign c_hot    = sel_onehot(C_SEL);
  assign inc_hot  = sel_onehot(INC_SEL);
  assign cpu_dmdr = c_hot[SLOT_DMDR] | inc_hot[SLOT_DMDR];
  assign mem_fire = mem_rd_valid & mem_rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      pend_data    <= '0;
      mem_rd_ready <= 1'b1;
    end else begin
      state        <= state_n;
      mem_rd_ready <= (state_n == ST_IDLE);
      if (pend_cap) pend_data <= mem_rd_data;
    end
  end

  // DMDR priority: C write, increment (via cbus_reg), held memory word, new memory word.
  always_comb begin
    state_n   = state;
    pend_cap  = 1'b0;
    dmdr_ld   = 1'b0;
    dmdr_data = c_in;
    case (state)
      ST_IDLE: begin
        if (mem_fire) begin
          if (cpu_dmdr) begin
            state_n  = ST_PEND;
            pend_cap = 1'b1;
          end else begin
            dmdr_ld   = 1'b1;
            dmdr_data = mem_rd_data;
          end
        end
      end
      ST_PEND: begin
        if (!cpu_dmdr) begin
          state_n   = ST_IDLE;
          dmdr_ld   = 1'b1;
          dmdr_data = pend_data;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (c_hot[SLOT_DMDR]) begin
      dmdr_ld   = 1'b1;
      dmdr_data = c_in;
    end
  end

  always_comb begin
    ld_vec            = c_hot;
    ld_vec[SLOT_DMDR] = dmdr_ld;
    for (int i = 0; i < NSLOT; i++) ld_data[i] = c_in;
    ld_data[SLOT_DMDR] = dmdr_data;
  end

  for (genvar i = 0; i < NSLOT; i++) begin : g_reg
    cbus_reg u_reg (
      .clk     (clk),
      .rst     (rst),
      .ld      (ld_vec[i]),
      .ld_data (ld_data[i]),
      .inc     (inc_hot[i]),
      .q       (regs[i])
    );
  end

  assign DMAR = regs[0];
  assign DMDR = regs[1];
  assign R0   = regs[2];
  assign R1   = regs[3];
  assign R2   = regs[4];
  assign R3   = regs[5];
  assign R4   = regs[6];
  assign R5   = regs[7];
  assign R6   = regs[8];
  assign R7   = regs[9];
  assign R8   = regs[10];
  assign R9   = regs[11];
  assign R10  = regs[12];
  assign R11  = regs[13];

`ifdef CBUS_WB_ZFLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             zflag <= 1'b0;
    else if (|c_hot)     zflag <= (c_in == '0);
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && (C_SEL == csel_rsvd || INC_SEL == csel_rsvd))
      $warning("cbus_writeback: reserved select code 4'hF ignored");
  end
`endif

endmodule

// File: doc/cbus_writeback.md
Name: cbus_writeback

Overview:
- Write-back end of the datapath bus system. The A bus reads a register onto the ALU input; this block takes the ALU result on the C bus and writes it into the selected register.
- Owns the architectural register bank: DMAR, DMDR and R0..R11, all 19 bits wide. Their outputs feed the A bus sources.
- Also handles register increments for loop counters and address stepping.
- Also handles DMDR loads from data memory through a valid/ready handshake, with a one-entry hold buffer for collisions.

Parameters:
- WIDTH, 19, datapath and register width.
- NREG, 12, number of general registers (R0..R11); the C_SEL encoding fixes this value.

Ports:
- clk  input  1  datapath clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- C_SEL  input  4  destination select for c_in; uses the same code space as A_SEL.
- c_in  input  WIDTH  ALU result on the C bus.
- INC_SEL  input  4  register to increment by 1 this cycle; same code space as C_SEL.
- mem_rd_valid  input  1  data memory presents read data.
- mem_rd_data  input  WIDTH  data memory read word.
- mem_rd_ready  output  1  block can accept the memory word this cycle.
- DMAR, DMDR  output  WIDTH each  memory address and memory data registers.
- R0..R11  output  WIDTH each  general registers.

Behaviour:
- Reset: on rst high, asynchronously clear all of the following:
  - DMAR, DMDR and R0..R11 to 0;
  - the hold buffer (pend_valid=0, pend_data=0);
  - mem_rd_ready is 1 while not pending.
- Select code map (C_SEL and INC_SEL):
  - 0000 = none;
  - 0001 = DMAR;
  - 0010 = DMDR;
  - 0011..1110 = R0..R11;
  - 1111 = reserved, no effect.
- C bus write: when C_SEL selects a register, that register takes c_in at the next rising edge. Latency is 1 cycle; the new value is visible on the output, and so to the A bus, the following cycle.
- Increment: the register selected by INC_SEL takes its current value + 1, modulo 2^WIDTH. 19'h7FFFF wraps to 0 with no carry out.
- Same register on C_SEL and INC_SEL: the C bus write wins and the increment is dropped.
- Different registers on C_SEL and INC_SEL: both update in the same cycle.
- Memory load handshake: the load transfers on a rising edge where mem_rd_valid=1 and mem_rd_ready=1.
  - mem_rd_ready = !pend_valid.
  - Memory holds valid and data until the transfer.
- Load with no DMDR conflict: if neither C_SEL nor INC_SEL targets DMDR, DMDR takes mem_rd_data.
- Load with DMDR conflict (C_SEL or INC_SEL targets DMDR):
  - the CPU update is applied to DMDR;
  - mem_rd_data is captured into pend_data and pend_valid is set.
- Draining the hold buffer: while pend_valid=1, on the first edge where neither C_SEL nor INC_SEL targets DMDR:
  - DMDR takes pend_data;
  - pend_valid clears, so ready returns the next cycle.
  - While pending, a CPU write/increment to DMDR still wins and the buffer keeps waiting.
- Priority on DMDR, highest first: C write, then increment, then pending memory data, then new memory data. A new memory transfer cannot occur while pending.
- Reset mid-operation: a pending load is discarded and no partial register update is retained.
- Reserved code 1111: no write and no increment. Under simulation a warning is printed.

Optional Feature:
- Macro: CBUS_WB_ZFLAG_EN.
- With it defined, an extra output port zflag (1 bit, reset 0) is registered on every C bus write. Value is 1 if c_in == 0, else 0.
- zflag holds when C_SEL is none or reserved; increments and memory loads do not affect it.
- Without the macro, the port and its logic are absent.

Decomposition:
- Shared package/include ctrlsigdef.v contains:
  - the 4-bit select codes: csel_none, csel_dmar, csel_dmdr, csel_r0..csel_r11, csel_rsvd;
  - the WIDTH constant (19).
  - A_SEL and C_SEL share these codes.
- Sub-module cbus_reg: one WIDTH-bit register with load, load data, inc and async rst.
  - Load beats inc.
  - Instanced 14 times.
  - DMDR's load mux is fed by the memory/pending logic in the top.

Test Plan:
- Reset then write: assert rst mid-cycle, then C_SEL=0011, c_in=19'h12345 -> all outputs 0 during rst; R0=19'h12345 one edge after release; all others still 0.
- Wrap increment: write R5=19'h7FFFF, then INC_SEL=1000 for 2 cycles -> R5=0, then 1.
- Write/inc collision: C_SEL=INC_SEL=0110 (R3), c_in=19'h00010 -> R3=19'h00010, not 19'h00011. Separately C_SEL=R1 with INC_SEL=R2 -> both updated the same edge.
- Memory load, clean: mem_rd_valid=1, data=19'h0ABCD, C_SEL=none -> DMDR=19'h0ABCD next cycle; mem_rd_ready stays 1.
- Memory collision: mem_rd_valid=1, data=19'h00777, C_SEL=0010, c_in=19'h00001 -> DMDR=1 and mem_rd_ready=0. Next idle cycle -> DMDR=19'h00777, ready=1. A second held valid during pending is not consumed.
- Reserved/zflag (macro on):
  - C_SEL=1111 -> no register changes.
  - C_SEL=R7, c_in=0 -> zflag=1.
  - C_SEL=R7, c_in=5 -> zflag=0.
  - Idle cycle -> zflag holds.
